dbx_tile_issuer: RTL and testbench

DBX_TILE_ISSUER -- requirements
Module: dbx_tile_issuer

---
 rtl/dbx_tile_issuer.sv | 159 +++++++++++++++
 tb/tb_dbx_tile_issuer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbx_tile_issuer.sv
// Captures one job (dx scalar + full B vector), streams it to the dBx array one tile
// per cycle, then counts returned results and flags protocol errors.
module dbx_tile_issuer #(
  parameter int DW        = 16,
  parameter int N_TILE    = 16,
  parameter int N_TOTAL   = 128,
  parameter int MUL_LAT   = 6,
  localparam int NUM_TILES = N_TOTAL / N_TILE,
  localparam int IW        = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DW-1:0]           dx_i,
  input  logic [N_TOTAL*DW-1:0]   B_i,
  output logic                    valid_o,
  output logic [DW-1:0]           dx_o,
  output logic [N_TILE*DW-1:0]    Bmat_o,
  output logic [IW-1:0]           tile_idx_o,
  input  logic                    res_valid_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int TW   = N_TILE * DW;
  localparam int CW   = $clog2(NUM_TILES + 1);
  localparam int DLIM = MUL_LAT + NUM_TILES;
  localparam int DCW  = $clog2(DLIM + 1);

  localparam logic [CW-1:0]  RET_FULL  = CW'(NUM_TILES);
  localparam logic [DCW-1:0] DRAIN_MAX = DCW'(DLIM);
  localparam logic [DCW-1:0] DRAIN_TO  = DCW'(DLIM - 1);
  localparam logic [IW-1:0]  LAST_IDX  = IW'(NUM_TILES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [TW-1:0]  tiles_q [NUM_TILES];
  logic [TW-1:0]  tiles_d [NUM_TILES];
  logic [DW-1:0]  dx_q, dx_d;
  logic [TW-1:0]  bmat_q, bmat_d;
  logic [IW-1:0]  tile_q, tile_d;
  logic           valid_q, valid_d;
  logic [CW-1:0]  ret_q, ret_d;
  logic [DCW-1:0] drain_q, drain_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic [IW-1:0]  tile_nx;
  logic [CW-1:0]  issued;
  logic           last_tile;
  logic           complete;

  assign in_ready   = (state_q == S_IDLE) && !rst;
  assign busy_o     = (state_q != S_IDLE);
  assign valid_o    = valid_q;
  assign dx_o       = dx_q;
  assign Bmat_o     = bmat_q;
  assign tile_idx_o = tile_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

  assign tile_nx   = tile_q + IW'(1);
  assign last_tile = (tile_q == LAST_IDX);
  // Tile on the bus this cycle already counts as issued, so a same-cycle return is legal.
  assign issued    = (state_q == S_ISSUE) ? (CW'(tile_q) + CW'(1)) : RET_FULL;
  assign complete  = res_valid_i && (ret_q == RET_FULL - CW'(1)) &&
                     ((state_q == S_DRAIN) || ((state_q == S_ISSUE) && last_tile));

  always_comb begin
    state_d = state_q;
    tiles_d = tiles_q;
    dx_d    = dx_q;
    bmat_d  = bmat_q;
    tile_d  = tile_q;
    valid_d = valid_q;
    ret_d   = ret_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    err_d   = err_q;

    if (res_valid_i && ((state_q == S_IDLE) || (ret_q == RET_FULL) || (ret_q >= issued)))
      err_d = 1'b1;
    if (res_valid_i && (state_q != S_IDLE) && (ret_q != RET_FULL))
      ret_d = ret_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          state_d = S_ISSUE;
          for (int t = 0; t < NUM_TILES; t++) tiles_d[t] = B_i[t*TW +: TW];
          dx_d    = dx_i;
          bmat_d  = B_i[0 +: TW];
          tile_d  = '0;
          valid_d = 1'b1;
          ret_d   = '0;
          drain_d = '0;
        end
      end
      S_ISSUE: begin
        if (last_tile) begin
          valid_d = 1'b0;
          drain_d = '0;
          if (complete) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          tile_d = tile_nx;
          bmat_d = tiles_q[tile_nx];
        end
      end
      S_DRAIN: begin
        if (complete) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          if (drain_q != DRAIN_MAX) drain_d = drain_q + DCW'(1);
          // No auto-recovery on timeout: stay in DRAIN so the hang stays visible.
          if (drain_q >= DRAIN_TO) err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int t = 0; t < NUM_TILES; t++) tiles_q[t] <= '0;
      dx_q    <= '0;
      bmat_q  <= '0;
      tile_q  <= '0;
      valid_q <= 1'b0;
      ret_q   <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tiles_q <= tiles_d;
      dx_q    <= dx_d;
      bmat_q  <= bmat_d;
      tile_q  <= tile_d;
      valid_q <= valid_d;
      ret_q   <= ret_d;
      drain_q <= drain_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dbx_tile_issuer.sv
// Bench for dbx_tile_issuer: job-level reference model plus a small dBx return emulator,
// with directed scenarios and a randomized traffic phase.
module tb_dbx_tile_issuer;
  localparam int DW   = 16;
  localparam int NT   = 8;
  localparam int NTOT = 64;
  localparam int ML   = 6;
  localparam int NTL  = NTOT / NT;
  localparam int IW   = 3;
  localparam int TW   = NT * DW;
  localparam int LIM  = ML + NTL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [DW-1:0] dx_i = '0;
  logic [NTOT*DW-1:0] B_i = '0;
  logic valid_o;
  logic [DW-1:0] dx_o;
  logic [TW-1:0] Bmat_o;
  logic [IW-1:0] tile_idx_o;
  logic res_valid_i = 1'b0;
  logic busy_o, done_o, err_o;

  dbx_tile_issuer #(.DW(DW), .N_TILE(NT), .N_TOTAL(NTOT), .MUL_LAT(ML)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dx_i(dx_i), .B_i(B_i), .valid_o(valid_o), .dx_o(dx_o), .Bmat_o(Bmat_o),
    .tile_idx_o(tile_idx_o), .res_valid_i(res_valid_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // reference model: a job is described by its acceptance cycle and results seen so far
  bit m_busy = 0, m_err = 0, m_done = 0;
  int m_acc = -100;
  int m_ret = 0;
  logic [DW-1:0] m_dx;
  logic [DW-1:0] m_b [NTOT];

  // dBx emulation and observation logs
  int rq[$];
  int env_lat = ML;
  bit withhold = 0;
  bit noise = 0;
  int iv_stop = 1000000;
  int done_log[$];
  int vlog[$];
  logic [TW-1:0] t3_bmat;
  logic [DW-1:0] t3_dx;
  int err_rise = -1;

  task automatic chk(input string nm, input logic [TW-1:0] a, input logic [TW-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, a, e);
    end
  endtask

  task automatic compare();
    int k;
    bit ev;
    logic [TW-1:0] eb;
    k = cyc - m_acc - 1;
    ev = m_busy && (k >= 0) && (k < NTL);
    chk("valid_o", valid_o, ev);
    chk("busy_o", busy_o, m_busy);
    chk("in_ready", in_ready, !m_busy && !rst);
    chk("done_o", done_o, m_done);
    chk("err_o", err_o, m_err);
    if (ev) begin
      chk("tile_idx_o", tile_idx_o, k[IW-1:0]);
      chk("dx_o", dx_o, m_dx);
      for (int j = 0; j < NT; j++) eb[j*DW +: DW] = m_b[k*NT + j];
      chk("Bmat_o", Bmat_o, eb);
    end
    if (done_o) done_log.push_back(cyc);
    if (valid_o) vlog.push_back(cyc);
    if (valid_o && tile_idx_o == 3'd3) begin
      t3_bmat = Bmat_o;
      t3_dx = dx_o;
    end
    if (err_o && err_rise < 0) err_rise = cyc;
  endtask

  task automatic model_update(input bit iv, input bit rv);
    int k, issued;
    bit nd;
    nd = 0;
    if (rst) begin
      m_busy = 0; m_err = 0; m_done = 0;
      return;
    end
    k = cyc - m_acc - 1;
    if (!m_busy) begin
      if (rv) m_err = 1;
      if (iv) begin
        m_busy = 1; m_acc = cyc; m_ret = 0; m_dx = dx_i;
        for (int n = 0; n < NTOT; n++) m_b[n] = B_i[n*DW +: DW];
      end
    end else begin
      issued = (k < NTL) ? k + 1 : NTL;
      if (rv) begin
        if (m_ret >= NTL || m_ret + 1 > issued) m_err = 1;
        m_ret++;
      end
      if (rv && m_ret == NTL && k >= NTL - 1) begin
        m_busy = 0;
        nd = 1;
      end else if (k >= NTL && (k - NTL + 1) >= LIM) begin
        m_err = 1;
      end
    end
    m_done = nd;
  endtask

  task automatic randomize_inputs();
    dx_i = DW'($urandom());
    for (int w = 0; w < NTOT*DW/32; w++) B_i[w*32 +: 32] = $urandom();
  endtask

  task automatic step(input bit iv, input bit extra_rv);
    bit rv;
    @(posedge clk);
    #1;
    cyc++;
    compare();
    if (valid_o && !(withhold && tile_idx_o == IW'(NTL-1))) rq.push_back(cyc + env_lat);
    rv = extra_rv;
    for (int i = rq.size() - 1; i >= 0; i--)
      if (rq[i] == cyc) begin
        rv = 1;
        rq.delete(i);
      end
    if (noise) randomize_inputs();
    in_valid = iv && (done_log.size() < iv_stop);
    res_valid_i = rv;
    model_update(in_valid, rv);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    #1;
    chk("rst_valid_o", valid_o, 1'b0);
    chk("rst_busy_o", busy_o, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_done_o", done_o, 1'b0);
    chk("rst_err_o", err_o, 1'b0);
    m_busy = 0; m_err = 0; m_done = 0;
    repeat (n) step(0, 0);
    in_valid = 1'b0;
    res_valid_i = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    int t;
    bit found;

    // reset state
    repeat (2) step(0, 0);
    chk("init_tile_idx", tile_idx_o, '0);
    chk("init_dx_o", dx_o, '0);
    chk("init_bmat", Bmat_o, '0);
    rst = 1'b0;
    step(0, 0);
    chk("post_rst_in_ready", in_ready, 1'b1);

    // single directed job with a known B pattern
    dx_i = 16'h4000;
    for (int n = 0; n < NTOT; n++) B_i[n*DW +: DW] = 16'h3C00 + 16'(n);
    done_log.delete(); vlog.delete();
    step(1, 0);
    t = cyc;
    repeat (24) step(0, 0);
    chk("job1_valid_count", vlog.size(), NTL);
    if (vlog.size() == NTL) begin
      chk("job1_first_tile_cyc", vlog[0] - t, 1);
      chk("job1_last_tile_cyc", vlog[NTL-1] - t, 8);
    end
    chk("job1_done_count", done_log.size(), 1);
    if (done_log.size() >= 1) chk("job1_done_cyc", done_log[0] - t, 15);
    chk("job1_t3_el0", t3_bmat[DW-1:0], 16'h3C18);
    chk("job1_t3_el7", t3_bmat[TW-1 -: DW], 16'h3C1F);
    chk("job1_t3_dx", t3_dx, 16'h4000);

    // back-to-back: in_valid held high for two jobs
    randomize_inputs();
    done_log.delete(); vlog.delete();
    iv_stop = 2;
    repeat (40) step(1, 0);
    iv_stop = 1000000;
    repeat (4) step(0, 0);
    chk("b2b_done_count", done_log.size(), 2);
    found = 0;
    if (done_log.size() >= 1)
      foreach (vlog[i]) if (vlog[i] == done_log[0] + 1) found = 1;
    chk("b2b_next_burst", found, 1'b1);
    chk("b2b_tile_count", vlog.size(), 2*NTL);

    // spurious result in IDLE, then a clean job: err stays set
    step(0, 1);
    step(0, 0);
    chk("spurious_err", err_o, 1'b1);
    randomize_inputs();
    step(1, 0);
    repeat (20) step(0, 0);
    chk("spurious_err_sticky", err_o, 1'b1);

    // reset while tile 3 is on the bus; stale results then arrive in IDLE
    randomize_inputs();
    done_log.delete();
    step(1, 0);
    repeat (4) step(0, 0);
    chk("pre_rst_tile3", tile_idx_o, 3'd3);
    do_reset(1);
    step(0, 0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    repeat (10) step(0, 0);
    chk("mid_rst_no_done", done_log.size(), 0);
    chk("mid_rst_late_err", err_o, 1'b1);

    // randomized traffic
    do_reset(2);
    rq.delete();
    noise = 1;
    done_log.delete();
    for (int c = 0; c < 800; c++) begin
      if (!m_busy && rq.size() == 0) env_lat = $urandom_range(1, ML);
      step($urandom_range(0, 3) == 0, 0);
    end
    noise = 0;
    repeat (20) step(0, 0);
    chk("rand_some_jobs", done_log.size() > 10, 1'b1);

    // last result withheld: drain timeout
    do_reset(2);
    rq.delete();
    env_lat = ML;
    withhold = 1;
    err_rise = -1;
    randomize_inputs();
    step(1, 0);
    t = cyc;
    repeat (30) step(0, 0);
    chk("timeout_err_rise", err_rise - t, 23);
    chk("timeout_busy", busy_o, 1'b1);
    withhold = 0;
    do_reset(1);
    step(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
